// File: rtl/sequenced_instruction_decoder_pkg.sv
// Shared opcode field constants, phase encoding and the opcode classifier
// used by the sequenced instruction decoder.
package sequenced_instruction_decoder_pkg;

    // Phase ring: one-hot, one bit per phase.
    localparam int PH_W            = 4;
    localparam int IDX_FETCH       = 0;
    localparam int IDX_DECODE      = 1;
    localparam int IDX_EXECUTE     = 2;
    localparam int IDX_INCREMENT   = 3;

    typedef enum logic [PH_W-1:0] {
        PH_FETCH     = 4'b0001,
        PH_DECODE    = 4'b0010,
        PH_EXECUTE   = 4'b0100,
        PH_INCREMENT = 4'b1000
    } phase_t;

    // Opcode class prefixes, matched against the top bits of the instruction.
    localparam logic [1:0] CLS_LOAD     = 2'b00;
    localparam logic [1:0] CLS_ADD      = 2'b01;
    localparam logic [2:0] CLS_SUB      = 3'b101;
    localparam logic [2:0] CLS_BITAND   = 3'b111;
    localparam logic [2:0] CLS_RESERVED = 3'b110;
    localparam logic [3:0] CLS_JUMP     = 4'b1000;
    localparam logic [3:0] CLS_JCOND    = 4'b1001;

    // Condition codes in instruction bits [3:2] of the conditional-jump class.
    localparam logic [1:0] CC_Z  = 2'b00;
    localparam logic [1:0] CC_C  = 2'b01;
    localparam logic [1:0] CC_NZ = 2'b10;
    localparam logic [1:0] CC_NC = 2'b11;

    typedef struct packed {
        logic op;
        logic load;
        logic add;
        logic sub;
        logic bitand_f;
        logic jump;
        logic jumpz;
        logic jumpnz;
        logic jumpc;
        logic jumpnc;
    } strobes_t;

    // Bits [1:0] never influence the decode, so only [7:2] are taken.
    function automatic strobes_t decode_opcode(input logic [7:2] insn);
        strobes_t s;
        s = '0;
        if (insn[7:6] == CLS_LOAD) begin
            s.load = 1'b1;
            s.op   = 1'b1;
        end else if (insn[7:6] == CLS_ADD) begin
            s.add = 1'b1;
            s.op  = 1'b1;
        end else if (insn[7:5] == CLS_SUB) begin
            s.sub = 1'b1;
            s.op  = 1'b1;
        end else if (insn[7:5] == CLS_BITAND) begin
            s.bitand_f = 1'b1;
            s.op       = 1'b1;
        end else if (insn[7:4] == CLS_JUMP) begin
            s.jump = 1'b1;
        end else if (insn[7:4] == CLS_JCOND) begin
            case (insn[3:2])
                CC_Z:    s.jumpz  = 1'b1;
                CC_NZ:   s.jumpnz = 1'b1;
                CC_C:    s.jumpc  = 1'b1;
                default: s.jumpnc = 1'b1;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/sequenced_instruction_decoder_phase_ring.sv
// Four-phase one-hot sequencer: fetch -> decode -> execute -> increment.
// Clear forces fetch and overrides the enable.
module phase_ring
    import sequenced_instruction_decoder_pkg::*;
(
    input  logic clock,
    input  logic input_clear,
    input  logic input_clock_enable,
    output logic fetch,
    output logic decode,
    output logic execute,
    output logic increment
);

    phase_t r_phase;

    always_ff @(posedge clock) begin
        if (input_clear) begin
            r_phase <= PH_FETCH;
        end else if (input_clock_enable) begin
            case (r_phase)
                PH_FETCH:     r_phase <= PH_DECODE;
                PH_DECODE:    r_phase <= PH_EXECUTE;
                PH_EXECUTE:   r_phase <= PH_INCREMENT;
                PH_INCREMENT: r_phase <= PH_FETCH;
                // An upset non-one-hot state recovers to fetch.
                default:      r_phase <= PH_FETCH;
            endcase
        end
    end

    assign fetch     = r_phase[IDX_FETCH];
    assign decode    = r_phase[IDX_DECODE];
    assign execute   = r_phase[IDX_EXECUTE];
    assign increment = r_phase[IDX_INCREMENT];

endmodule

// File: rtl/sequenced_instruction_decoder.sv
// Control-unit front end: phase ring plus combinational, phase-qualified decode.
// Optional macro SEQ_DECODER_ILLEGAL_EN adds output_illegal for reserved opcodes.
module sequenced_instruction_decoder
    import sequenced_instruction_decoder_pkg::*;
(
    input  logic       clock,
    input  logic       input_clear,
    input  logic       input_clock_enable,
    input  logic [7:0] input_a,
    output logic       fetch,
    output logic       decode,
    output logic       execute,
    output logic       increment,
    output logic       output_ip,
    output logic       output_op,
    output logic       output_load,
    output logic       output_add,
    output logic       output_sub,
    output logic       output_bitand,
    output logic       output_jump,
    output logic       output_jumpz,
    output logic       output_jumpnz,
    output logic       output_jumpc,
    output logic       output_jumpnc
`ifdef SEQ_DECODER_ILLEGAL_EN
    ,
    output logic       output_illegal
`endif
);

    strobes_t w_dec;
    strobes_t w_gated;
    logic     w_unused;

    phase_ring u_phase_ring (
        .clock              (clock),
        .input_clear        (input_clear),
        .input_clock_enable (input_clock_enable),
        .fetch              (fetch),
        .decode             (decode),
        .execute            (execute),
        .increment          (increment)
    );

    assign w_dec    = decode_opcode(input_a[7:2]);
    assign w_unused = ^input_a[1:0];

    // Every strobe except the IR strobe is valid only during execute.
    assign w_gated = execute ? w_dec : '0;

    assign output_ip     = decode;
    assign output_op     = w_gated.op;
    assign output_load   = w_gated.load;
    assign output_add    = w_gated.add;
    assign output_sub    = w_gated.sub;
    assign output_bitand = w_gated.bitand_f;
    assign output_jump   = w_gated.jump;
    assign output_jumpz  = w_gated.jumpz;
    assign output_jumpnz = w_gated.jumpnz;
    assign output_jumpc  = w_gated.jumpc;
    assign output_jumpnc = w_gated.jumpnc;

`ifdef SEQ_DECODER_ILLEGAL_EN
    assign output_illegal = execute && (input_a[7:5] == CLS_RESERVED);
`endif

endmodule

// File: tb/tb_sequenced_instruction_decoder.sv
// Directed bench for sequenced_instruction_decoder: reset, phase walk, hold,
// opcode sweep, phase gating, reserved opcode and clear mid-execute.
module tb_sequenced_instruction_decoder;

    logic       clock = 1'b0;
    logic       input_clear;
    logic       input_clock_enable;
    logic [7:0] input_a;
    logic       fetch, decode, execute, increment;
    logic       output_ip, output_op, output_load, output_add, output_sub, output_bitand;
    logic       output_jump, output_jumpz, output_jumpnz, output_jumpc, output_jumpnc;
`ifdef SEQ_DECODER_ILLEGAL_EN
    logic       output_illegal;
`endif

    int checks = 0;
    int errors = 0;

    // Strobe vector order: {ip, op, load, add, sub, bitand, jump, jz, jnz, jc, jnc}
    localparam logic [10:0] S_NONE   = 11'b000_0000_0000;
    localparam logic [10:0] S_IP     = 11'b100_0000_0000;
    localparam logic [10:0] S_OP     = 11'b010_0000_0000;
    localparam logic [10:0] S_LOAD   = 11'b001_0000_0000;
    localparam logic [10:0] S_ADD    = 11'b000_1000_0000;
    localparam logic [10:0] S_SUB    = 11'b000_0100_0000;
    localparam logic [10:0] S_BITAND = 11'b000_0010_0000;
    localparam logic [10:0] S_JUMP   = 11'b000_0001_0000;
    localparam logic [10:0] S_JZ     = 11'b000_0000_1000;
    localparam logic [10:0] S_JNZ    = 11'b000_0000_0100;
    localparam logic [10:0] S_JC     = 11'b000_0000_0010;
    localparam logic [10:0] S_JNC    = 11'b000_0000_0001;

    // Phase vector order: {fetch, decode, execute, increment}
    localparam logic [3:0] P_F = 4'b1000;
    localparam logic [3:0] P_D = 4'b0100;
    localparam logic [3:0] P_E = 4'b0010;
    localparam logic [3:0] P_I = 4'b0001;

    sequenced_instruction_decoder dut (
        .clock              (clock),
        .input_clear        (input_clear),
        .input_clock_enable (input_clock_enable),
        .input_a            (input_a),
        .fetch              (fetch),
        .decode             (decode),
        .execute            (execute),
        .increment          (increment),
        .output_ip          (output_ip),
        .output_op          (output_op),
        .output_load        (output_load),
        .output_add         (output_add),
        .output_sub         (output_sub),
        .output_bitand      (output_bitand),
        .output_jump        (output_jump),
        .output_jumpz       (output_jumpz),
        .output_jumpnz      (output_jumpnz),
        .output_jumpc       (output_jumpc),
        .output_jumpnc      (output_jumpnc)
`ifdef SEQ_DECODER_ILLEGAL_EN
        ,
        .output_illegal     (output_illegal)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] strobes();
        return {output_ip, output_op, output_load, output_add, output_sub, output_bitand,
                output_jump, output_jumpz, output_jumpnz, output_jumpc, output_jumpnc};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_ph, input logic [10:0] exp_st);
        logic [3:0]  ph;
        logic [10:0] st;
        ph = {fetch, decode, execute, increment};
        st = strobes();
        checks++;
        assert (ph === exp_ph)
        else begin
            errors++;
            $error("FAIL %s phase observed=%b expected=%b", tag, ph, exp_ph);
        end
        checks++;
        assert (st === exp_st)
        else begin
            errors++;
            $error("FAIL %s strobes observed=%b expected=%b", tag, st, exp_st);
        end
        $display("step %-14s a=%b phase=%b strobes=%b", tag, input_a, ph, st);
    endtask

    logic [7:0]  sweep_a   [12];
    logic [10:0] sweep_exp [12];

    initial begin
        sweep_a[0]  = 8'b0000_0000; sweep_exp[0]  = S_OP | S_LOAD;
        sweep_a[1]  = 8'b0001_0000; sweep_exp[1]  = S_OP | S_LOAD;
        sweep_a[2]  = 8'b0100_0000; sweep_exp[2]  = S_OP | S_ADD;
        sweep_a[3]  = 8'b0110_0000; sweep_exp[3]  = S_OP | S_ADD;
        sweep_a[4]  = 8'b1010_0000; sweep_exp[4]  = S_OP | S_SUB;
        sweep_a[5]  = 8'b1110_0000; sweep_exp[5]  = S_OP | S_BITAND;
        sweep_a[6]  = 8'b1000_0000; sweep_exp[6]  = S_JUMP;
        sweep_a[7]  = 8'b1001_0000; sweep_exp[7]  = S_JZ;
        sweep_a[8]  = 8'b1001_1000; sweep_exp[8]  = S_JNZ;
        sweep_a[9]  = 8'b1001_0100; sweep_exp[9]  = S_JC;
        sweep_a[10] = 8'b1001_1111; sweep_exp[10] = S_JNC;
        sweep_a[11] = 8'b1100_0000; sweep_exp[11] = S_NONE;

        input_clear        = 1'b1;
        input_clock_enable = 1'b1;
        input_a            = 8'b0000_0000;

        // Reset: clear for two edges, held with enable high.
        tick();
        check("reset1", P_F, S_NONE);
        tick();
        check("reset2", P_F, S_NONE);

        // Phase walk with a load instruction.
        input_clear = 1'b0;
        tick(); check("walk_d", P_D, S_IP);
        tick(); check("walk_e", P_E, S_OP | S_LOAD);
        tick(); check("walk_i", P_I, S_NONE);
        tick(); check("walk_f", P_F, S_NONE);

        // Hold in decode for three edges.
        tick(); check("hold_entry", P_D, S_IP);
        input_clock_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_d", P_D, S_IP);
        end
        input_a = 8'b1100_0000;
        #1 check("dec_rsvd_ip", P_D, S_IP);

        // Opcode sweep while held in execute; decode follows input_a combinationally.
        input_clock_enable = 1'b1;
        tick();
        input_clock_enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            input_a = sweep_a[i];
            #1 check($sformatf("sweep%0d", i), P_E, sweep_exp[i]);
        end
`ifdef SEQ_DECODER_ILLEGAL_EN
        checks++;
        assert (output_illegal === 1'b1)
        else begin
            errors++;
            $error("FAIL illegal_exec observed=%b expected=1", output_illegal);
        end
`endif
        tick();
        check("hold_e", P_E, S_NONE);

        // Gating: ALU opcodes outside execute produce nothing.
        input_clock_enable = 1'b1;
        input_a = 8'b0100_0000;
        tick(); check("gate_i", P_I, S_NONE);
`ifdef SEQ_DECODER_ILLEGAL_EN
        input_a = 8'b1100_0000;
        #1;
        checks++;
        assert (output_illegal === 1'b0)
        else begin
            errors++;
            $error("FAIL illegal_inc observed=%b expected=0", output_illegal);
        end
`endif
        input_a = 8'b1110_0000;
        tick(); check("gate_f", P_F, S_NONE);

        // Clear mid-execute (with enable high): next edge forces fetch.
        input_a = 8'b1000_0000;
        tick(); check("clr_d", P_D, S_IP);
        tick(); check("clr_e", P_E, S_JUMP);
        input_clear = 1'b1;
        tick(); check("clr_f", P_F, S_NONE);
        tick(); check("clr_hold", P_F, S_NONE);
        input_clear = 1'b0;
        tick(); check("clr_rel_d", P_D, S_IP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
